// File: rtl/hilo_ctrl_if.sv
// Request-side bus of hilo_ctrl: opcode/operands, multiplier product, and ready/busy status.
interface hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic        sign;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [63:0] mul_res;
    logic        op_ready;
    logic        busy;

    modport master (output op_valid, op, sign, data_a, data_b, mul_res,
                    input  op_ready, busy);
    modport slave  (input  op_valid, op, sign, data_a, data_b, mul_res,
                    output op_ready, busy);
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: MUL/MTHI/MTLO complete on accept, DIV runs through an external divider.
// Optional multiply-accumulate (MADD/MSUB) is enabled by defining HILO_MADD_EN.
module hilo_ctrl #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    hilo_ctrl_if.slave  req,
    input  logic        flush,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_sign,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz_err,
    output logic        to_err
);
    localparam int CW = $clog2(DIV_TIMEOUT) + 1;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MADD = 3'b011;
    localparam logic [2:0] OP_MSUB = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b101;
    localparam logic [2:0] OP_MTLO = 3'b110;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [63:0]   hilo_nxt;
    logic          lat, dz_nxt, to_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        hilo_nxt = {hi, lo};
        lat      = 1'b0;
        dz_nxt   = 1'b0;
        to_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req.op_valid) begin
                    case (req.op)
                        OP_MUL:  hilo_nxt = req.mul_res;
                        OP_MTHI: hilo_nxt[63:32] = req.data_a;
                        OP_MTLO: hilo_nxt[31:0]  = req.data_a;
`ifdef HILO_MADD_EN
                        OP_MADD: hilo_nxt = {hi, lo} + req.mul_res;
                        OP_MSUB: hilo_nxt = {hi, lo} - req.mul_res;
`else
                        OP_MADD, OP_MSUB: ;
`endif
                        OP_DIV: begin
                            if (req.data_b == 32'd0) begin
                                dz_nxt = 1'b1;
                            end else begin
                                lat = 1'b1;
                                nxt = START;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            START: begin
                cnt_nxt = '0;
                nxt     = flush ? IDLE : WAIT;
            end
            WAIT: begin
                // flush outranks both completion and timeout
                if (flush) begin
                    nxt = IDLE;
                end else if (div_done) begin
                    hilo_nxt = {div_r, div_q};
                    nxt      = IDLE;
                end else if (cnt == CW'(DIV_TIMEOUT - 1)) begin
                    to_nxt = 1'b1;
                    nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_a    <= '0;
            div_b    <= '0;
            div_sign <= 1'b0;
            dz_err   <= 1'b0;
            to_err   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            hi     <= hilo_nxt[63:32];
            lo     <= hilo_nxt[31:0];
            dz_err <= dz_nxt;
            to_err <= to_nxt;
            if (lat) begin
                div_a    <= req.data_a;
                div_b    <= req.data_b;
                div_sign <= req.sign;
            end
        end
    end

    assign div_start    = (state == START);
    assign req.op_ready = (state == IDLE);
    assign req.busy     = (state != IDLE);
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: cycle-accurate transaction model plus literal checkpoints.
module tb_hilo_ctrl;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        div_done = 1'b0;
    logic [31:0] div_q = '0, div_r = '0;
    logic [31:0] div_a, div_b, hi, lo;
    logic        div_sign, div_start, dz_err, to_err;

    hilo_ctrl_if bus();

    hilo_ctrl #(.DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus), .flush(flush),
        .div_a(div_a), .div_b(div_b), .div_sign(div_sign), .div_start(div_start),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .hi(hi), .lo(lo), .dz_err(dz_err), .to_err(to_err)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int busy_cnt = 0, ds_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Model: m_since = cycles since a DIV was accepted (-1 when idle).
    int          m_since;
    logic [63:0] m_hilo;
    logic [31:0] m_da, m_db;
    logic        m_ds, m_dz, m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since = -1; m_hilo = '0; m_da = '0; m_db = '0; m_ds = 0; m_dz = 0; m_to = 0;
        end else begin
            m_dz = 0; m_to = 0;
            if (m_since < 0) begin
                if (bus.op_valid) begin
                    case (bus.op)
                        3'd1: m_hilo = bus.mul_res;
                        3'd5: m_hilo = {bus.data_a, m_hilo[31:0]};
                        3'd6: m_hilo = {m_hilo[63:32], bus.data_a};
`ifdef HILO_MADD_EN
                        3'd3: m_hilo = m_hilo + bus.mul_res;
                        3'd4: m_hilo = m_hilo - bus.mul_res;
`endif
                        3'd2: if (bus.data_b == 0) m_dz = 1;
                              else begin m_da = bus.data_a; m_db = bus.data_b; m_ds = bus.sign; m_since = 0; end
                        default: ;
                    endcase
                end
            end else if (flush) begin
                m_since = -1;
            end else if (m_since == 0) begin
                m_since = 1;
            end else if (div_done) begin
                m_hilo = {div_r, div_q}; m_since = -1;
            end else if (m_since - 1 == TO - 1) begin
                m_to = 1; m_since = -1;
            end else begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin
        busy_cnt += int'(bus.busy);
        ds_cnt   += int'(div_start);
        chk("ready", bus.op_ready, m_since < 0);
        chk("busy", bus.busy, m_since >= 0);
        chk("div_start", div_start, m_since == 0);
        chk("hi", hi, m_hilo[63:32]);
        chk("lo", lo, m_hilo[31:0]);
        chk("dz_err", dz_err, m_dz);
        chk("to_err", to_err, m_to);
        chk("div_a", div_a, m_da);
        chk("div_b", div_b, m_db);
        chk("div_sign", div_sign, m_ds);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [2:0] op, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] mr);
        step();
        bus.op_valid = 1'b1; bus.op = op; bus.sign = s;
        bus.data_a = a; bus.data_b = b; bus.mul_res = mr;
        step();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        bus.op_valid = 0; bus.op = 0; bus.sign = 0;
        bus.data_a = 0; bus.data_b = 0; bus.mul_res = 0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_hi", hi, 0);
        chk("rst_ready", bus.op_ready, 1);

        send(3'd5, 0, 32'h1234_5678, 0, 0);
        chk("mthi", hi, 32'h1234_5678);
        send(3'd6, 0, 32'h9ABC_DEF0, 0, 0);
        chk("mtlo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);

        busy_cnt = 0;
        send(3'd1, 1, 32'hFFFF_FFFE, 3, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul_ready", bus.op_ready, 1);
        chk("mul_busy_cnt", busy_cnt, 0);

        busy_cnt = 0; ds_cnt = 0;
        send(3'd2, 1, 7, 2, 0);
        chk("div_start1", div_start, 1);
        chk("div_a_lat", div_a, 7);
        repeat (6) step();
        div_done = 1; div_q = 3; div_r = 1;
        step();
        div_done = 0;
        chk("div_res", {hi, lo}, {32'd1, 32'd3});
        chk("div_busy7", busy_cnt, 7);
        chk("div_start_once", ds_cnt, 1);

        ds_cnt = 0;
        send(3'd2, 0, 5, 0, 0);
        chk("dz_pulse", dz_err, 1);
        chk("dz_hilo", {hi, lo}, {32'd1, 32'd3});
        step();
        chk("dz_once", dz_err, 0);
        chk("dz_nostart", ds_cnt, 0);

        send(3'd2, 0, 20, 3, 0);
        step();
        flush = 1; div_done = 1; div_q = 6; div_r = 2;
        step();
        flush = 0; div_done = 0;
        chk("flush_ready", bus.op_ready, 1);
        chk("flush_hilo", {hi, lo}, {32'd1, 32'd3});

        flush = 1;
        send(3'd5, 0, 32'hCAFE_0001, 0, 0);
        flush = 0;
        chk("idle_flush_mthi", hi, 32'hCAFE_0001);

        busy_cnt = 0;
        send(3'd2, 0, 9, 3, 0);
        for (int i = 0; i < 200 && !bus.op_ready; i++) step();
        chk("to_ready", bus.op_ready, 1);
        chk("to_pulse", to_err, 1);
        chk("to_busy65", busy_cnt, 65);
        chk("to_hilo", {hi, lo}, {32'hCAFE_0001, 32'd3});

        send(3'd7, 0, 32'hDEAD_BEEF, 0, 64'h1);
        chk("rsv_hilo", {hi, lo}, {32'hCAFE_0001, 32'd3});

        send(3'd5, 0, 32'hFFFF_FFFF, 0, 0);
        send(3'd6, 0, 32'hFFFF_FFFF, 0, 0);
        send(3'd3, 0, 0, 0, 64'h1);
`ifdef HILO_MADD_EN
        chk("madd_wrap", {hi, lo}, 64'h0);
        send(3'd4, 0, 0, 0, 64'h1);
        chk("msub_wrap", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("madd_off", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        send(3'd4, 0, 0, 0, 64'h1);
        chk("msub_off", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        send(3'd2, 1, 5, 1, 0);
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hilo", {hi, lo}, 64'h0);
        chk("arst_div", {div_a, div_b}, 64'h0);
        chk("arst_ctl", {div_sign, div_start, bus.busy, dz_err, to_err}, 5'b0);
        #1 rst_n = 1'b1;
        step();
        div_done = 1; div_q = 32'h55; div_r = 32'h66;
        step();
        div_done = 0;
        chk("late_done_ready", bus.op_ready, 1);
        chk("late_done_hilo", {hi, lo}, 64'h0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
